// File: rtl/e_mdu_if.sv
// e_mdu_if: request/result bundle between the E stage and the multiply/divide unit.
//
// Handshake: the E stage raises start for exactly the cycle it wants an
// operation issued; op, A and B are sampled at that rising edge only. The unit
// does not back-pressure through this bundle. It raises busy while a
// multiply/divide is in flight, and the stall unit must hold dependent
// instructions in D while busy is high. done is a one-cycle pulse in the cycle
// HI/LO first show a new mult/div result.
//
//   start  master->slave  issue request, qualified by op
//   op     master->slave  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A, B   master->slave  rs / rt operands
//   busy   slave->master  multiply or divide in flight
//   done   slave->master  commit pulse
//   hi, lo slave->master  architectural HI / LO
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning the architectural HI/LO.
//
// The result is computed combinationally from the operands at the start edge
// and parked in res_hi/res_lo. A down-counter then models the pipeline latency.
// HI/LO update only at the commit edge, so they keep their old values while
// busy is high.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset; aborts any in-flight operation
//   bus        e_mdu_if slave (start/op/A/B in, busy/done/hi/lo out)
//   dbg_state  current FSM state (0 IDLE, 1 RUN)
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave bus,
    output logic   dbg_state
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    logic             issue;
    logic             last;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    // Ops 0..3 take the multi-cycle path. MTHI/MTLO and the no-ops never go busy.
    assign issue = bus.start && !bus.op[2];
    assign last  = (cnt == CW'(1));

    // Combinational arithmetic
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, uq_s, ur_s, q_s, r_s, q_u, r_u;
    logic               b_zero;

    always_comb begin
        prod_s = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) * $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
        prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

        // Signed divide via magnitudes. Most-negative / -1 falls out naturally:
        // |A| = 2^(W-1), quotient negates back to A and the remainder is 0.
        a_neg  = bus.A[WIDTH-1];
        b_neg  = bus.B[WIDTH-1];
        a_mag  = a_neg ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag  = b_neg ? (~bus.B + WIDTH'(1)) : bus.B;
        b_zero = (bus.B == '0);
        uq_s   = b_zero ? '0 : (a_mag / b_mag);
        ur_s   = b_zero ? '0 : (a_mag % b_mag);
        q_s    = (a_neg ^ b_neg) ? (~uq_s + WIDTH'(1)) : uq_s;
        r_s    = a_neg ? (~ur_s + WIDTH'(1)) : ur_s;
        q_u    = b_zero ? '0 : (bus.A / bus.B);
        r_u    = b_zero ? '0 : (bus.A % bus.B);

        nxt_hi = '0;
        nxt_lo = '0;
        case (bus.op[1:0])
            2'd0: begin nxt_hi = prod_s[2*WIDTH-1:WIDTH]; nxt_lo = prod_s[WIDTH-1:0]; end
            2'd1: begin nxt_hi = prod_u[2*WIDTH-1:WIDTH]; nxt_lo = prod_u[WIDTH-1:0]; end
            2'd2: begin nxt_hi = r_s; nxt_lo = q_s; end
            default: begin nxt_hi = r_u; nxt_lo = q_u; end
        endcase
        // Divide by zero is defined: LO all ones, HI the dividend.
        if (bus.op[1] && b_zero) begin
            nxt_hi = bus.A;
            nxt_lo = '1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (issue) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Any start seen in RUN is ignored, including MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (issue) begin
                    res_hi <= nxt_hi;
                    res_lo <= nxt_lo;
                    cnt    <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end else if (bus.start && bus.op == 3'd4) begin
                    hi_q <= bus.A;
                end else if (bus.start && bus.op == 3'd5) begin
                    lo_q <= bus.A;
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (last) begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = (state == RUN);
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu at the default parameters
// (WIDTH=32, 5/10 cycles) and at WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3. Inputs
// are driven and outputs sampled on the falling edge.
module tb_e_mdu;
    // clock / reset
    logic clk = 1'b0;
    logic rst32, rst8;
    logic st32, st8;
    always #5 clk = ~clk;

    e_mdu_if #(.WIDTH(32)) b32();
    e_mdu_if #(.WIDTH(8))  b8();

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u32 (
        .clk(clk), .reset(rst32), .bus(b32), .dbg_state(st32));
    e_mdu #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) u8 (
        .clk(clk), .reset(rst8), .bus(b8), .dbg_state(st8));

    int tests = 0;
    int fails = 0;

    // scoreboard: expected {hi,lo} of each issued mult/div, popped at commit
    logic [63:0] exp_q[$];
    logic [31:0] m_hi32 = '0, m_lo32 = '0;
    logic [7:0]  m_hi8  = '0, m_lo8  = '0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // reference model: arithmetic straight from the operation rules
    function automatic void ref_mdu(input int w, input logic [2:0] o, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] rh, output logic [63:0] rl);
        logic [63:0] mask, up;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin p = sa * sb; rh = 64'(p >>> w) & mask; rl = 64'(p) & mask; end
            3'd1: begin up = a * b; rh = (up >> w) & mask; rl = up & mask; end
            3'd2: begin
                if (b == 0) begin rh = a; rl = mask; end
                else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin rh = 0; rl = a; end
                else begin q = sa / sb; r = sa % sb; rh = 64'(r) & mask; rl = 64'(q) & mask; end
            end
            default: begin
                if (b == 0) begin rh = a; rl = mask; end
                else begin rh = a % b; rl = a / b; end
            end
        endcase
    endfunction

    // done may never be high in two consecutive cycles
    logic prev_d32 = 1'b0, prev_d8 = 1'b0;
    always @(negedge clk) begin
        if (b32.done) begin
            tests++;
            assert (!prev_d32) else begin fails++; $error("FAIL done32_double observed=1 expected=0"); end
        end
        if (b8.done) begin
            tests++;
            assert (!prev_d8) else begin fails++; $error("FAIL done8_double observed=1 expected=0"); end
        end
        prev_d32 = b32.done;
        prev_d8  = b8.done;
    end

    // 32-bit mult/div with cycle-by-cycle checks; optional intruding starts during RUN
    task automatic op32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit intrude);
        int n;
        n = o[1] ? 10 : 5;
        exp_q.push_back({eh, el});
        @(negedge clk);
        b32.start = 1'b1; b32.op = o; b32.A = a; b32.B = b;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check($sformatf("busy32_c%0d", k), {63'd0, b32.busy}, 64'd1);
            check($sformatf("hold32_c%0d", k), {b32.hi, b32.lo}, {m_hi32, m_lo32});
            b32.start = 1'b0;
            b32.A = $urandom; b32.B = $urandom;
            if (intrude && k == 2) begin b32.start = 1'b1; b32.op = 3'd5; b32.A = 32'h55; end
            if (intrude && k == 4) begin b32.start = 1'b1; b32.op = 3'd0; b32.A = 32'd3; b32.B = 32'd4; end
        end
        @(negedge clk);
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("done32", {62'd0, b32.done, b32.busy}, 64'd2);
            check("result32", {b32.hi, b32.lo}, e);
            m_hi32 = e[63:32];
            m_lo32 = e[31:0];
        end
        @(negedge clk);
        check("done32_off", {63'd0, b32.done}, 64'd0);
    endtask

    task automatic mt32(input logic [2:0] o, input logic [31:0] a);
        if (o == 3'd4) m_hi32 = a;
        else           m_lo32 = a;
        @(negedge clk);
        b32.start = 1'b1; b32.op = o; b32.A = a;
        @(negedge clk);
        b32.start = 1'b0;
        check("mt32_value", {b32.hi, b32.lo}, {m_hi32, m_lo32});
        check("mt32_flags", {62'd0, b32.busy, b32.done}, 64'd0);
    endtask

    task automatic rand32();
        logic [2:0] o;
        logic [31:0] a, b;
        logic [63:0] rh, rl;
        o = 3'($urandom_range(0, 3));
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        ref_mdu(32, o, {32'd0, a}, {32'd0, b}, rh, rl);
        op32(o, a, b, rh[31:0], rl[31:0], 1'b0);
    endtask

    // 8-bit op of any code; measures busy width and checks the commit
    task automatic op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] rh, rl;
        int cnt;
        @(negedge clk);
        b8.start = 1'b1; b8.op = o; b8.A = a; b8.B = b;
        @(negedge clk);
        b8.start = 1'b0;
        b8.A = 8'($urandom); b8.B = 8'($urandom);
        if (o <= 3'd3) begin
            ref_mdu(8, o, {56'd0, a}, {56'd0, b}, rh, rl);
            check("hold8", {48'd0, b8.hi, b8.lo}, {48'd0, m_hi8, m_lo8});
            cnt = 0;
            while (b8.busy && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            check("busy8_width", 64'(cnt), o[1] ? 64'd3 : 64'd1);
            check("done8", {63'd0, b8.done}, 64'd1);
            m_hi8 = rh[7:0];
            m_lo8 = rl[7:0];
            check("result8", {48'd0, b8.hi, b8.lo}, {48'd0, m_hi8, m_lo8});
        end else begin
            if (o == 3'd4) m_hi8 = a;
            if (o == 3'd5) m_lo8 = a;
            check("mt8_flags", {62'd0, b8.busy, b8.done}, 64'd0);
            check("mt8_value", {48'd0, b8.hi, b8.lo}, {48'd0, m_hi8, m_lo8});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        b32.start = 1'b0; b32.op = 3'd0; b32.A = '0; b32.B = '0;
        b8.start  = 1'b0; b8.op  = 3'd0; b8.A  = '0; b8.B  = '0;
        rst32 = 1'b1; rst8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        check("reset32", {b32.hi, b32.lo}, 64'd0);
        check("reset32_flags", {61'd0, b32.busy, b32.done, st32}, 64'd0);
        check("reset8", {45'd0, b8.hi, b8.lo, b8.busy, b8.done, st8}, 64'd0);

        // directed default-parameter cases
        op32(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        op32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        op32(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        op32(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        op32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        op32(3'd2, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0);
        mt32(3'd4, 32'h1234);
        mt32(3'd5, 32'hCAFE);
        // MTLO and MULT during a DIV must be ignored
        op32(3'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

        // reset in cycle 4 of a DIV aborts it without a commit
        @(negedge clk);
        b32.start = 1'b1; b32.op = 3'd2; b32.A = 32'd50; b32.B = 32'd3;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b32.start = 1'b0;
            if (k == 4) rst32 = 1'b1;
        end
        @(negedge clk);
        rst32 = 1'b0;
        m_hi32 = '0; m_lo32 = '0;
        check("abort_busy", {62'd0, b32.busy, b32.done}, 64'd0);
        check("abort_hilo", {b32.hi, b32.lo}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                seen = seen | b32.done;
            end
            check("abort_no_done", {63'd0, seen}, 64'd0);
        end

        for (int i = 0; i < 20; i++) rand32();

        // WIDTH=8 sweep
        for (int i = 0; i < 1000; i++) begin
            logic [2:0] o;
            logic [7:0] a, b;
            int r;
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'h00;
            if (r == 1) begin a = 8'h80; b = 8'hFF; end
            op8(o, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
